// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: response owner encoding,
// conflict counter ceiling and the write-enable helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_CPU  = 2'd1,
    RSP_HOST = 2'd2
  } rsp_owner_e;

  localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

  // Byte enables presented to the RAM: strobes for a write, nothing for a read.
  function automatic logic [3:0] eff_we(input logic we, input logic [3:0] wstrb);
    return we ? wstrb : 4'b0000;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Bounded counter of consecutive CPU grants taken while the host waits.
// Clear wins over increment; the count holds at STARVE_MAX.
module starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [7:0] MAX_L = 8'(STARVE_MAX);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc && (cnt_q != MAX_L)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_L);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store unit and the
// AXI-Lite host port, with CPU priority bounded by a starvation counter.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 8
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              cpu_running,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_wdata,
  input  logic [3:0]        cpu_req_wstrb,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rsp_rdata,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_we,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [31:0]       host_req_wdata,
  input  logic [3:0]        host_req_wstrb,
  output logic              host_rsp_valid,
  output logic [31:0]       host_rsp_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       conflict_cnt
);

  logic              at_max;
  logic              host_wins;
  logic              host_grant;
  logic              cpu_grant;
  logic              sel_we;
  logic [3:0]        sel_wstrb;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              starve_inc;
  logic              starve_clr;

  rsp_owner_e        rsp_owner_q, rsp_owner_d;
  logic              rsp_is_read_q, rsp_is_read_d;
  logic [15:0]       conflict_q, conflict_d;

  // Grants are suppressed while reset is asserted so every output reads 0.
  always_comb begin
    host_wins  = !cpu_running || !cpu_req_valid || at_max;
    host_grant = S_AXI_ARESETN && host_wins && host_req_valid;
    cpu_grant  = S_AXI_ARESETN && !host_wins && cpu_req_valid;

    sel_we    = host_grant ? host_req_we    : cpu_req_we;
    sel_wstrb = host_grant ? host_req_wstrb : cpu_req_wstrb;
    sel_addr  = host_grant ? host_req_addr  : cpu_req_addr;
    sel_wdata = host_grant ? host_req_wdata : cpu_req_wdata;

    cpu_req_ready  = cpu_grant;
    host_req_ready = host_grant;

    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_grant || cpu_grant) begin
      // A write with no strobes is acknowledged but never reaches the RAM.
      mem_en    = !(sel_we && (sel_wstrb == 4'b0000));
      mem_we    = eff_we(sel_we, sel_wstrb);
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end

    starve_inc = cpu_grant && host_req_valid;
    starve_clr = host_grant || !host_req_valid;
  end

  starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .at_max(at_max)
  );

  always_comb begin
    rsp_owner_d   = RSP_NONE;
    rsp_is_read_d = 1'b0;
    if (cpu_grant) begin
      rsp_owner_d   = RSP_CPU;
      rsp_is_read_d = !cpu_req_we;
    end else if (host_grant) begin
      rsp_owner_d   = RSP_HOST;
      rsp_is_read_d = !host_req_we;
    end

    conflict_d = conflict_q;
    if (cpu_req_valid && host_req_valid && (conflict_q != CONFLICT_MAX)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rsp_owner_q   <= RSP_NONE;
      rsp_is_read_q <= 1'b0;
      conflict_q    <= 16'd0;
    end else begin
      rsp_owner_q   <= rsp_owner_d;
      rsp_is_read_q <= rsp_is_read_d;
      conflict_q    <= conflict_d;
    end
  end

  // Gating with reset drops a response that was pending when reset arrived.
  always_comb begin
    cpu_rsp_valid  = S_AXI_ARESETN && (rsp_owner_q == RSP_CPU);
    host_rsp_valid = S_AXI_ARESETN && (rsp_owner_q == RSP_HOST);
    cpu_rsp_rdata  = (cpu_rsp_valid && rsp_is_read_q) ? mem_rdata : 32'd0;
    host_rsp_rdata = (host_rsp_valid && rsp_is_read_q) ? mem_rdata : 32'd0;
    conflict_cnt   = S_AXI_ARESETN ? conflict_q : 16'd0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by random traffic,
// all compared every cycle against a word-level reference model.
module tb_dmem_port_arbiter;

  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 8;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_running;
  logic              cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [31:0]       cpu_req_wdata;
  logic [3:0]        cpu_req_wstrb;
  logic              cpu_rsp_valid;
  logic [31:0]       cpu_rsp_rdata;
  logic              host_req_valid, host_req_ready, host_req_we;
  logic [ADDR_W-1:0] host_req_addr;
  logic [31:0]       host_req_wdata;
  logic [3:0]        host_req_wstrb;
  logic              host_rsp_valid;
  logic [31:0]       host_rsp_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [15:0]       conflict_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .cpu_running   (cpu_running),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_req_wstrb (cpu_req_wstrb),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .host_req_valid(host_req_valid),
    .host_req_ready(host_req_ready),
    .host_req_we   (host_req_we),
    .host_req_addr (host_req_addr),
    .host_req_wdata(host_req_wdata),
    .host_req_wstrb(host_req_wstrb),
    .host_rsp_valid(host_rsp_valid),
    .host_rsp_rdata(host_rsp_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .conflict_cnt  (conflict_cnt)
  );

  // Synchronous-read RAM attached to the arbiter's memory port.
  logic [31:0] tb_ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) begin
        mem_rdata <= tb_ram[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) tb_ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [DEPTH];
  int          m_starve;
  int          m_conflict;
  int          pend_owner;        // 0 none, 1 cpu, 2 host
  logic [31:0] pend_data;
  logic [31:0] exp_q[$];          // read data expected, in issue order
  int          total = 0;
  int          bad   = 0;

  logic        last_cg, last_hg;
  logic        s_cpu_rv, s_host_rv, s_mem_en;
  logic [3:0]  s_mem_we;
  logic [31:0] s_cpu_rdata, s_host_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check every output mid-cycle, then advance the model.
  task automatic cyc();
    logic              hw, hg, cg, sw, xfer, en;
    logic [3:0]        sst, ewe;
    logic [ADDR_W-1:0] sa;
    logic [31:0]       sd, erd;
    @(negedge clk);
    hg = 1'b0;
    cg = 1'b0;
    if (rst_n) begin
      hw = !cpu_running || !cpu_req_valid || (m_starve == STARVE_MAX);
      hg = hw && host_req_valid;
      cg = !hw && cpu_req_valid;
    end
    xfer = hg || cg;
    sw   = hg ? host_req_we    : cpu_req_we;
    sst  = hg ? host_req_wstrb : cpu_req_wstrb;
    sa   = hg ? host_req_addr  : cpu_req_addr;
    sd   = hg ? host_req_wdata : cpu_req_wdata;
    en   = xfer && !(sw && sst == 4'b0000);
    ewe  = (en && sw) ? sst : 4'b0000;

    chk("cpu_req_ready", 32'(cpu_req_ready), 32'(cg));
    chk("host_req_ready", 32'(host_req_ready), 32'(hg));
    chk("mem_en", 32'(mem_en), 32'(en));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_addr", 32'(mem_addr), xfer ? 32'(sa) : 32'd0);
    chk("mem_wdata", mem_wdata, xfer ? sd : 32'd0);
    erd = 32'd0;
    if (rst_n && pend_owner != 0) erd = pend_data;
    chk("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(rst_n && pend_owner == 1));
    chk("cpu_rsp_rdata", cpu_rsp_rdata, (pend_owner == 1) ? erd : 32'd0);
    chk("host_rsp_valid", 32'(host_rsp_valid), 32'(rst_n && pend_owner == 2));
    chk("host_rsp_rdata", host_rsp_rdata, (pend_owner == 2) ? erd : 32'd0);
    chk("conflict_cnt", 32'(conflict_cnt), rst_n ? 32'(m_conflict) : 32'd0);

    last_cg      = cg;
    last_hg      = hg;
    s_cpu_rv     = cpu_rsp_valid;
    s_host_rv    = host_rsp_valid;
    s_cpu_rdata  = cpu_rsp_rdata;
    s_host_rdata = host_rsp_rdata;
    s_mem_en     = mem_en;
    s_mem_we     = mem_we;

    @(posedge clk);
    if (!rst_n) begin
      m_starve   = 0;
      m_conflict = 0;
      pend_owner = 0;
      pend_data  = 32'd0;
    end else begin
      if (cpu_req_valid && host_req_valid && m_conflict < 65535) m_conflict++;
      if (hg || !host_req_valid) m_starve = 0;
      else if (cg && m_starve < STARVE_MAX) m_starve++;
      pend_owner = cg ? 1 : (hg ? 2 : 0);
      pend_data  = (xfer && !sw) ? ref_mem[sa] : 32'd0;
      if (xfer && !sw) exp_q.push_back(ref_mem[sa]);
      if (en && sw) begin
        for (int b = 0; b < 4; b++) begin
          if (sst[b]) ref_mem[sa][8*b +: 8] = sd[8*b +: 8];
        end
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cpu(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    cpu_req_valid = v;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    cpu_req_wstrb = s;
  endtask

  task automatic set_host(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    host_req_valid = v;
    host_req_we    = we;
    host_req_addr  = a;
    host_req_wdata = d;
    host_req_wstrb = s;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, '0, 32'd0, 4'd0);
    set_host(1'b0, 1'b0, '0, 32'd0, 4'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_ram[i]  = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem_rdata   = 32'd0;
    m_starve    = 0;
    m_conflict  = 0;
    pend_owner  = 0;
    pend_data   = 32'd0;
    rst_n       = 1'b0;
    cpu_running = 1'b1;
    // Requests asserted during reset must not be granted.
    set_cpu(1'b1, 1'b0, 12'h001, 32'd0, 4'd0);
    set_host(1'b1, 1'b0, 12'h002, 32'd0, 4'd0);
    #1;
    cyc();
    cyc();
    chk("reset_no_grant", 32'({last_cg, last_hg}), 32'd0);
    idle();
    rst_n = 1'b1;
    cyc();

    // Host-only write then read.
    set_host(1'b1, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF);
    cyc();
    chk("host_wr_we", 32'(s_mem_we), 32'hF);
    set_host(1'b1, 1'b0, 12'h005, 32'd0, 4'h0);
    cyc();
    chk("host_wr_ack", 32'(s_host_rv), 32'd1);
    chk("host_rd_we", 32'(s_mem_we), 32'h0);
    idle();
    cyc();
    chk("host_rd_ack", 32'(s_host_rv), 32'd1);
    chk("host_rd_data", s_host_rdata, 32'hDEADBEEF);

    // CPU streaming with the host always waiting: 8 CPU grants then 1 host.
    set_cpu(1'b1, 1'b0, 12'h005, 32'd0, 4'd0);
    set_host(1'b1, 1'b0, 12'h007, 32'd0, 4'd0);
    for (int k = 0; k < 27; k++) begin
      cyc();
      chk("starve_pattern_cpu", 32'(last_cg), 32'((k % 9) != 8));
      chk("starve_pattern_host", 32'(last_hg), 32'((k % 9) == 8));
    end
    chk("conflict_after_stream", 32'(m_conflict), 32'd27);

    // CPU halted: host owns the port.
    cpu_running = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("halted_cpu_ready", 32'(last_cg), 32'd0);
      chk("halted_host_grant", 32'(last_hg), 32'd1);
    end
    cpu_running = 1'b1;
    idle();
    cyc();

    // Byte-lane write merge.
    set_host(1'b1, 1'b1, 12'h020, 32'h11223344, 4'hF);
    cyc();
    set_host(1'b0, 1'b0, '0, 32'd0, 4'd0);
    set_cpu(1'b1, 1'b1, 12'h020, 32'h0000AB00, 4'b0010);
    cyc();
    chk("byte_we", 32'(s_mem_we), 32'h2);
    set_cpu(1'b1, 1'b0, 12'h020, 32'd0, 4'd0);
    cyc();
    idle();
    cyc();
    chk("byte_readback", s_cpu_rdata, 32'h1122AB44);

    // Strobe-less write is a no-op that still acknowledges.
    set_cpu(1'b1, 1'b1, 12'h003, 32'hFFFFFFFF, 4'b0000);
    cyc();
    chk("noop_mem_en", 32'(s_mem_en), 32'd0);
    chk("noop_accept", 32'(last_cg), 32'd1);
    idle();
    cyc();
    chk("noop_ack", 32'(s_cpu_rv), 32'd1);
    chk("noop_rdata", s_cpu_rdata, 32'd0);

    // Reset in the cycle after a CPU read drops the response.
    set_cpu(1'b1, 1'b0, 12'h020, 32'd0, 4'd0);
    cyc();
    idle();
    rst_n = 1'b0;
    cyc();
    chk("rst_drop_rsp", 32'(s_cpu_rv), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rst_drop_after", 32'(s_cpu_rv), 32'd0);

    // Random traffic; a request not accepted is held unchanged.
    for (int n = 0; n < 600; n++) begin
      if (!(cpu_req_valid && !last_cg)) begin
        set_cpu($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                12'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      end
      if (!(host_req_valid && !last_hg)) begin
        set_host($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                 12'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      end
      cpu_running = ($urandom_range(0, 9) < 8);
      rst_n       = ($urandom_range(0, 59) != 0);
      cyc();
    end

    rst_n = 1'b1;
    idle();
    cyc();
    cyc();
    total++;
    assert (exp_q.size() > 50) else begin
      bad++;
      $error("FAIL read_volume observed=%0d expected=>50", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
